// File: rtl/tower_spawner.sv
// tower_spawner: chooses the spawn column for each falling tower and paces
// spawns in whole video frames. A tower leaving the screen (edgeCollide) starts
// a pseudo-random gap; when the gap expires a fresh column is published.
module tower_spawner #(
    parameter int          SCREEN_WIDTH   = 640,
    parameter int          TOWER_WIDTH    = 100,
    parameter int          X_MARGIN       = 0,
    parameter int          MIN_GAP_FRAMES = 30,
    parameter int          GAP_RAND_BITS  = 5,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               edgeCollide,
    output logic signed [10:0] topLeftX,
    output logic               towerValid,
    output logic               spawnPulse,
    output logic [7:0]         spawnCount
);

    // Number of legal columns; must lie in 512..1024 so one conditional
    // subtraction folds any 10-bit candidate into range.
    localparam int                SPAN      = SCREEN_WIDTH - TOWER_WIDTH - 2 * X_MARGIN + 1;
    localparam logic [10:0]       SPAN_V    = 11'(SPAN);
    localparam logic [10:0]       MARGIN_V  = 11'(X_MARGIN);
    localparam int                GAP_W     = 16;
    localparam logic [GAP_W-1:0]  MIN_GAP_V = GAP_W'(MIN_GAP_FRAMES);
    localparam logic [GAP_W-1:0]  GAP_ONE   = 16'd1;
    localparam logic [GAP_W-1:0]  GAP_ZERO  = 16'd0;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0]       LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GAP    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t            state_r;
    logic [15:0]       lfsr_r;
    logic [GAP_W-1:0]  gap_cnt_r;

    // One Galois LFSR step
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] shifted;
        shifted = {1'b0, v[15:1]};
        if (v[0]) begin
            lfsr_step = shifted ^ LFSR_TAPS;
        end else begin
            lfsr_step = shifted;
        end
    endfunction

    // Fold the low 10 LFSR bits into [0, SPAN) and offset by the margin
    function automatic logic [10:0] column_of(input logic [15:0] v);
        logic [10:0] cand;
        logic [10:0] red;
        cand = {1'b0, v[9:0]};
        if (cand >= SPAN_V) begin
            red = cand - SPAN_V;
        end else begin
            red = cand;
        end
        column_of = red + MARGIN_V;
    endfunction

    // Gap length uses LFSR bits above the column bits so the two stay uncorrelated
    function automatic logic [GAP_W-1:0] gap_of(input logic [15:0] v);
        gap_of = MIN_GAP_V + {{(GAP_W - GAP_RAND_BITS){1'b0}}, v[GAP_RAND_BITS+9:10]};
    endfunction

    // Free-running LFSR: advances every clock in every state, only reset reloads it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Spawn FSM with registered outputs; enable low parks it in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            gap_cnt_r  <= GAP_ZERO;
            topLeftX   <= 11'sd0;
            towerValid <= 1'b0;
            spawnPulse <= 1'b0;
            spawnCount <= 8'd0;
        end else begin
            spawnPulse <= 1'b0;
            if (!enable) begin
                // Column and spawn count are kept so the scene can resume cleanly
                state_r    <= ST_IDLE;
                towerValid <= 1'b0;
                gap_cnt_r  <= GAP_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        gap_cnt_r <= gap_of(lfsr_r);
                        state_r   <= ST_GAP;
                    end
                    ST_GAP: begin
                        if (startOfFrame) begin
                            if (gap_cnt_r != GAP_ZERO) begin
                                gap_cnt_r <= gap_cnt_r - GAP_ONE;
                            end else begin
                                topLeftX   <= $signed(column_of(lfsr_r));
                                towerValid <= 1'b1;
                                spawnPulse <= 1'b1;
                                if (spawnCount != 8'hFF) begin
                                    spawnCount <= spawnCount + 8'd1;
                                end else begin
                                    spawnCount <= spawnCount;
                                end
                                state_r <= ST_ACTIVE;
                            end
                        end else begin
                            gap_cnt_r <= gap_cnt_r;
                        end
                    end
                    ST_ACTIVE: begin
                        // A coincident frame pulse is not counted against the new gap
                        if (edgeCollide) begin
                            towerValid <= 1'b0;
                            gap_cnt_r  <= gap_of(lfsr_r);
                            state_r    <= ST_GAP;
                        end else begin
                            state_r <= ST_ACTIVE;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        towerValid <= 1'b0;
                        gap_cnt_r  <= GAP_ZERO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tower_spawner.sv
// tb_tower_spawner: directed stimulus with a reference model; expected spawn
// columns are queued when the causing frame is driven and popped on spawnPulse.
module tb_tower_spawner;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          SPAN = 541;
    localparam int          XM   = 0;

    logic               clk          = 1'b0;
    logic               reset        = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               enable       = 1'b0;
    logic               edgeCollide  = 1'b0;
    logic signed [10:0] topLeftX;
    logic               towerValid;
    logic               spawnPulse;
    logic [7:0]         spawnCount;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_lfsr;
    int          m_st;          // 0 idle, 1 gap, 2 active
    int          m_gap;
    int          m_valid;
    int          m_cnt;
    int          m_x;
    int          last_gap;
    int          sof_since_load;
    logic        exp_pulse;
    logic        saw_pulse;
    int          sb[$];

    tower_spawner dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .enable       (enable),
        .edgeCollide  (edgeCollide),
        .topLeftX     (topLeftX),
        .towerValid   (towerValid),
        .spawnPulse   (spawnPulse),
        .spawnCount   (spawnCount)
    );

    always #5 clk = ~clk;

    // Reference LFSR, Galois x^16+x^14+x^13+x^11+1 written out bit by bit
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr <= SEED;
        end else begin
            m_lfsr <= {m_lfsr[0], m_lfsr[15], m_lfsr[14] ^ m_lfsr[0], m_lfsr[13] ^ m_lfsr[0],
                       m_lfsr[12], m_lfsr[11] ^ m_lfsr[0], m_lfsr[10:1]};
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #5000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int exp_col(input logic [15:0] l);
        return XM + (int'(l[9:0]) % SPAN);
    endfunction

    function automatic int exp_gap(input logic [15:0] l);
        return 30 + int'(l[14:10]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_gap = 0; m_valid = 0; m_cnt = 0; m_x = 0;
        last_gap = 0; sof_since_load = 0; sb.delete();
    endtask

    // One clock: drive inputs at negedge, advance the model, check at next negedge
    task automatic cyc(input logic sof, input logic ec, input logic en);
        logic [15:0] l;
        int          e;
        startOfFrame = sof;
        edgeCollide  = ec;
        enable       = en;
        l            = m_lfsr;
        exp_pulse    = 1'b0;
        if (!en) begin
            m_st = 0; m_valid = 0; m_gap = 0;
        end else if (m_st == 0) begin
            last_gap = exp_gap(l); m_gap = last_gap; sof_since_load = 0; m_st = 1;
        end else if (m_st == 1) begin
            if (sof) begin
                sof_since_load++;
                if (m_gap == 0) begin
                    m_x = exp_col(l);
                    sb.push_back(m_x);
                    m_valid = 1; exp_pulse = 1'b1; m_st = 2;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    m_gap--;
                end
            end
        end else begin
            if (ec) begin
                m_valid = 0; last_gap = exp_gap(l); m_gap = last_gap; sof_since_load = 0; m_st = 1;
            end
        end
        @(negedge clk);
        chk("towerValid", towerValid, m_valid);
        chk("spawnPulse", spawnPulse, exp_pulse);
        chk("spawnCount", spawnCount, m_cnt);
        if (spawnPulse === 1'b1) begin
            saw_pulse = 1'b1;
            if (sb.size() == 0) begin
                chk("sb_nonempty", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("topLeftX_new", topLeftX, e);
                chk("x_range", ($signed(topLeftX) >= XM && $signed(topLeftX) <= 540 - XM), 1);
                chk("gap_frames", sof_since_load, last_gap + 1);
                chk("gap_range", (sof_since_load >= 31 && sof_since_load <= 62), 1);
            end
        end
        chk("topLeftX_hold", topLeftX, m_x);
    endtask

    task automatic frame(input logic ec, input logic en);
        cyc(1'b1, ec, en);
        cyc(1'b0, 1'b0, en);
    endtask

    task automatic run_to_spawn();
        saw_pulse = 1'b0;
        for (int i = 0; i < 100 && !saw_pulse; i++) frame(1'b0, 1'b1);
        chk("spawn_timeout", saw_pulse, 1);
    endtask

    initial begin
        logic found;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", towerValid, 0);
        chk("rst_pulse", spawnPulse, 0);
        chk("rst_count", spawnCount, 0);
        chk("rst_x", topLeftX, 0);
        chk("rst_lfsr", dut.lfsr_r, SEED);
        reset = 1'b0;

        // Disabled: 100 frames, nothing spawns
        for (int i = 0; i < 100; i++) frame(1'b0, 1'b0);

        // Wait for an LFSR state whose gap bits are zero, then enable (gap = 30)
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (m_lfsr[14:10] == 5'd0) found = 1'b1;
            else cyc(1'b0, 1'b0, 1'b0);
        end
        chk("seek_gap30", found, 1);
        cyc(1'b0, 1'b0, 1'b1);
        run_to_spawn();
        chk("first_count", spawnCount, 1);

        // edgeCollide coincident with startOfFrame
        frame(1'b0, 1'b1);
        frame(1'b1, 1'b1);
        chk("despawn_valid", towerValid, 0);
        run_to_spawn();

        // Long run: 300 spawns alternating coincident / isolated despawns
        for (int s = 0; s < 300; s++) begin
            frame(1'b0, 1'b1);
            if (s % 2 == 0) begin
                cyc(1'b0, 1'b1, 1'b1);
            end else begin
                frame(1'b1, 1'b1);
            end
            run_to_spawn();
        end
        chk("count_saturated", spawnCount, 255);

        // enable dropped mid-GAP, then re-enabled
        frame(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) frame(1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) frame(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        run_to_spawn();

        // enable dropped mid-ACTIVE, then re-enabled
        frame(1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("drop_active_valid", towerValid, 0);
        frame(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        run_to_spawn();

        // Asynchronous reset between edges while ACTIVE
        frame(1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", towerValid, 0);
        chk("async_pulse", spawnPulse, 0);
        chk("async_count", spawnCount, 0);
        chk("async_x", topLeftX, 0);
        chk("async_lfsr", dut.lfsr_r, SEED);
        @(negedge clk);
        chk("async_pulse_hold", spawnPulse, 0);
        chk("async_lfsr_hold", dut.lfsr_r, SEED);
        reset = 1'b0;
        model_reset();
        cyc(1'b0, 1'b0, 1'b1);
        run_to_spawn();
        chk("post_reset_count", spawnCount, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
